or1200_wbwriter: RTL and testbench
==================================

Name: or1200_wbwriter

Overview:
- Write-back stage writer for the OR1200 register file; it is the write-side counterpart of the operand read muxes.
- Selects the EX result from one of four sources: ALU, LSU, SPR or link address. It registers the result into the WB stage and drives the single RF write port.
- Publishes the registered result as wb_forw, with a validity flag, for the operand forwarding path.
- Stalls the pipeline while a load result is outstanding and writes each result exactly once, even under freeze.

Parameters:
width, 32, operand/result width (OR1200_OPERAND_WIDTH)
aw, 5, register file address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wb_freeze  in  1  WB stage freeze from pipeline freeze logic
rfwb_op  in  3  [0]=write enable, [2:1]=source select: 00 ALU, 01 LSU, 10 SPR, 11 LINK
ex_rfaddrw  in  aw  destination register of the EX instruction
alu_dataout  in  width  ALU result
lsu_dataout  in  width  load data, valid only with lsu_ack
lsu_ack  in  1  load data valid strobe
sprs_dataout  in  width  SPR read data
ex_pc  in  width  PC of the EX instruction
rf_we  out  1  RF write enable
rf_addrw  out  aw  RF write address
rf_dataw  out  width  RF write data
wb_forw  out  width  registered WB result, feeds the operand forwarding path
wb_rfaddrw  out  aw  destination register of the WB-stage entry
wb_fwd_valid  out  1  wb_forw is valid and may be forwarded
wb_stall  out  1  stall request while a load result is outstanding

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE, written=0.
  - wb_forw=0, wb_rfaddrw=0.
  - All outputs are 0 in the cycle after reset.
  - Reset mid-WAIT_LSU abandons the load; a later lsu_ack is ignored.
- States: IDLE (no valid entry), WAIT_LSU (load pending), READY (valid result held).
- Capture condition: cap = !wb_freeze && state!=WAIT_LSU. On cap, the EX instruction moves into WB:
  - wb_rfaddrw<=ex_rfaddrw; written<=0.
  - we_eff = rfwb_op[0] && ex_rfaddrw!=0. r0 is never written or forwarded.
  - If !we_eff: state->IDLE and wb_forw is unchanged.
  - If we_eff and sel!=LSU: wb_forw<=mux(sel) and state->READY.
    - ALU selects alu_dataout.
    - SPR selects sprs_dataout.
    - LINK selects ex_pc+8, truncated to width (wraps modulo 2^width).
  - If we_eff and sel==LSU and lsu_ack=1 in the same cycle: wb_forw<=lsu_dataout and state->READY.
  - If we_eff and sel==LSU and lsu_ack=0: state->WAIT_LSU.
- WAIT_LSU:
  - wb_stall=1 (combinational from state); no capture.
  - On lsu_ack: wb_forw<=lsu_dataout, state->READY, written<=0.
  - wb_freeze has no effect on this transition.
- READY:
  - rf_we = (state==READY) && !written, combinational.
  - rf_we rises in the first READY cycle; written<=1 at that edge.
  - If wb_freeze holds the entry, rf_we stays 0 until a new entry is captured. Exactly one write per entry.
  - A capture in a READY cycle replaces the entry at the edge; the old entry's write occurs in that same cycle.
- Output mapping:
  - rf_addrw=wb_rfaddrw and rf_dataw=wb_forw at all times.
  - wb_fwd_valid = (state==READY), independent of written.
- lsu_ack in IDLE or READY is ignored (no state or data change).
- Latency:
  - Non-load: captured at edge N, rf_we and wb_fwd_valid high in cycle N+1.
  - Load: result one cycle after the lsu_ack edge.

Test Plan:
- Reset, then ALU op: rfwb_op=3'b001, ex_rfaddrw=5, alu_dataout=32'h1234, wb_freeze=0 for one cycle -> next cycle rf_we=1, rf_addrw=5, rf_dataw=wb_forw=32'h1234, wb_fwd_valid=1.
- LINK wrap: rfwb_op=3'b111, ex_rfaddrw=9, ex_pc=32'hFFFF_FFFC -> wb_forw=32'h0000_0004, rf_we=1 for one cycle.
- Load with delay: rfwb_op=3'b011, ex_rfaddrw=3, lsu_ack low 3 cycles -> wb_stall=1 for 3 cycles and rf_we=0; lsu_ack=1 with lsu_dataout=32'hDEAD_BEEF -> next cycle wb_stall=0, rf_we=1, rf_dataw=32'hDEAD_BEEF.
- Freeze after capture: capture SPR op (rfwb_op=3'b101, sprs_dataout=32'h55, addr 7), then wb_freeze=1 for 4 cycles -> rf_we high exactly 1 cycle, wb_fwd_valid=1 all 4 cycles, wb_forw stable at 32'h55.
- r0 and no-write: rfwb_op=3'b001 with ex_rfaddrw=0, then rfwb_op=3'b000 with addr 4 -> rf_we=0 and wb_fwd_valid=0 throughout; spurious lsu_ack in IDLE leaves wb_forw unchanged.
- Reset in WAIT_LSU: issue load to r6, assert rst while waiting, then lsu_ack=1 -> state IDLE, wb_stall=0, rf_we never asserted.

Source files
------------

// File: rtl/or1200_wbwriter.sv
// Write-back stage writer for the OR1200 register file.
// Picks the EX result from ALU/LSU/SPR/LINK, holds it in the WB stage, and
// drives the single RF write port. A load that has not returned yet stalls
// the pipeline. Each held entry is written to the RF exactly once, even when
// the stage is frozen.
module or1200_wbwriter #(
    parameter int width = 32,
    parameter int aw    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_freeze,
    input  logic [2:0]       rfwb_op,
    input  logic [aw-1:0]    ex_rfaddrw,
    input  logic [width-1:0] alu_dataout,
    input  logic [width-1:0] lsu_dataout,
    input  logic             lsu_ack,
    input  logic [width-1:0] sprs_dataout,
    input  logic [width-1:0] ex_pc,
    output logic             rf_we,
    output logic [aw-1:0]    rf_addrw,
    output logic [width-1:0] rf_dataw,
    output logic [width-1:0] wb_forw,
    output logic [aw-1:0]    wb_rfaddrw,
    output logic             wb_fwd_valid,
    output logic             wb_stall
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LSU = 2'd1,
        READY    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LSU  = 2'b01,
        SEL_SPR  = 2'b10,
        SEL_LINK = 2'b11
    } sel_t;

    state_t           state;
    logic             written;
    logic             we_eff;
    logic             cap;
    sel_t             sel;
    logic [width-1:0] mux_data;

    assign sel    = sel_t'(rfwb_op[2:1]);
    // r0 is hard-wired to zero, so it is never written or forwarded.
    assign we_eff = rfwb_op[0] && (ex_rfaddrw != '0);
    // A pending load blocks the EX instruction from entering WB.
    assign cap    = !wb_freeze && (state != WAIT_LSU);

    // Result source mux for the non-load sources.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        mux_data = alu_dataout;
        case (sel)
            SEL_ALU:  mux_data = alu_dataout;
            SEL_SPR:  mux_data = sprs_dataout;
            SEL_LINK: mux_data = ex_pc + width'(8);
            default:  mux_data = alu_dataout;
        endcase
    end

    // WB-stage state machine: capture, load wait, and one-shot write tracking.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            written    <= 1'b0;
            wb_forw    <= '0;
            wb_rfaddrw <= '0;
        end else if (state == WAIT_LSU) begin
            // Load return is honoured even while frozen.
            if (lsu_ack) begin
                wb_forw <= lsu_dataout;
                state   <= READY;
                written <= 1'b0;
            end
        end else if (cap) begin
            wb_rfaddrw <= ex_rfaddrw;
            written    <= 1'b0;
            if (!we_eff) begin
                state <= IDLE;
            end else if (sel != SEL_LSU) begin
                wb_forw <= mux_data;
                state   <= READY;
            end else if (lsu_ack) begin
                wb_forw <= lsu_dataout;
                state   <= READY;
            end else begin
                state <= WAIT_LSU;
            end
        end else if (state == READY && !written) begin
            // Frozen entry: the write happens in this cycle, then never again.
            written <= 1'b1;
        end
    end

    assign rf_we        = (state == READY) && !written;
    assign rf_addrw     = wb_rfaddrw;
    assign rf_dataw     = wb_forw;
    assign wb_fwd_valid = (state == READY);
    assign wb_stall     = (state == WAIT_LSU);

endmodule

// File: tb/tb_or1200_wbwriter.sv
// Directed bench for or1200_wbwriter: expected RF writes are queued when an
// instruction is issued and popped by a monitor whenever rf_we fires.
module tb_or1200_wbwriter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_freeze;
    logic [2:0]  rfwb_op;
    logic [4:0]  ex_rfaddrw;
    logic [31:0] alu_dataout;
    logic [31:0] lsu_dataout;
    logic        lsu_ack;
    logic [31:0] sprs_dataout;
    logic [31:0] ex_pc;
    logic        rf_we;
    logic [4:0]  rf_addrw;
    logic [31:0] rf_dataw;
    logic [31:0] wb_forw;
    logic [4:0]  wb_rfaddrw;
    logic        wb_fwd_valid;
    logic        wb_stall;

    int  tests = 0;
    int  fails = 0;
    wr_t sb[$];

    or1200_wbwriter #(.width(32), .aw(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_freeze    (wb_freeze),
        .rfwb_op      (rfwb_op),
        .ex_rfaddrw   (ex_rfaddrw),
        .alu_dataout  (alu_dataout),
        .lsu_dataout  (lsu_dataout),
        .lsu_ack      (lsu_ack),
        .sprs_dataout (sprs_dataout),
        .ex_pc        (ex_pc),
        .rf_we        (rf_we),
        .rf_addrw     (rf_addrw),
        .rf_dataw     (rf_dataw),
        .wb_forw      (wb_forw),
        .wb_rfaddrw   (wb_rfaddrw),
        .wb_fwd_valid (wb_fwd_valid),
        .wb_stall     (wb_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && rf_we === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: addr %0d data %h, nothing expected", rf_addrw, rf_dataw);
            end
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(rf_addrw), 32'(e.addr));
                check("wr_data", rf_dataw, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_we;
        rst = 1'b1; wb_freeze = 1'b0; rfwb_op = 3'b000; ex_rfaddrw = 5'd0;
        alu_dataout = '0; lsu_dataout = '0; lsu_ack = 1'b0;
        sprs_dataout = '0; ex_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_rf_we",    32'(rf_we), 0);
        check("rst_wb_forw",  wb_forw, 0);
        check("rst_rfaddrw",  32'(wb_rfaddrw), 0);
        check("rst_valid",    32'(wb_fwd_valid), 0);
        check("rst_stall",    32'(wb_stall), 0);

        // ALU op to r5.
        rfwb_op = 3'b001; ex_rfaddrw = 5'd5; alu_dataout = 32'h1234;
        sb.push_back('{5'd5, 32'h1234});
        tick();
        rfwb_op = 3'b000;
        check("alu_we",    32'(rf_we), 1);
        check("alu_addr",  32'(rf_addrw), 5);
        check("alu_dataw", rf_dataw, 32'h1234);
        check("alu_forw",  wb_forw, 32'h1234);
        check("alu_valid", 32'(wb_fwd_valid), 1);
        tick();
        check("alu_idle_we",    32'(rf_we), 0);
        check("alu_idle_valid", 32'(wb_fwd_valid), 0);

        // Back-to-back ALU ops: the READY entry is written as it is replaced.
        rfwb_op = 3'b001; ex_rfaddrw = 5'd10; alu_dataout = 32'hA;
        sb.push_back('{5'd10, 32'hA});
        tick();
        ex_rfaddrw = 5'd11; alu_dataout = 32'hB;
        sb.push_back('{5'd11, 32'hB});
        tick();
        rfwb_op = 3'b000;
        check("b2b_we",   32'(rf_we), 1);
        check("b2b_forw", wb_forw, 32'hB);
        tick();

        // LINK wraps modulo 2^32.
        rfwb_op = 3'b111; ex_rfaddrw = 5'd9; ex_pc = 32'hFFFF_FFFC;
        sb.push_back('{5'd9, 32'h4});
        tick();
        rfwb_op = 3'b000;
        check("link_forw", wb_forw, 32'h4);
        check("link_we",   32'(rf_we), 1);
        tick();
        check("link_we_off", 32'(rf_we), 0);

        // Load with three cycles of delay.
        rfwb_op = 3'b011; ex_rfaddrw = 5'd3; lsu_ack = 1'b0;
        tick();
        rfwb_op = 3'b000;
        for (int i = 0; i < 3; i++) begin
            check("ld_stall", 32'(wb_stall), 1);
            check("ld_we",    32'(rf_we), 0);
            check("ld_valid", 32'(wb_fwd_valid), 0);
            if (i == 2) begin
                lsu_ack = 1'b1; lsu_dataout = 32'hDEAD_BEEF;
                sb.push_back('{5'd3, 32'hDEAD_BEEF});
            end
            tick();
        end
        lsu_ack = 1'b0;
        check("ld_stall_off", 32'(wb_stall), 0);
        check("ld_we_on",     32'(rf_we), 1);
        check("ld_dataw",     rf_dataw, 32'hDEAD_BEEF);
        check("ld_addr",      32'(rf_addrw), 3);
        tick();

        // SPR op then a four-cycle freeze: single write, entry held.
        rfwb_op = 3'b101; ex_rfaddrw = 5'd7; sprs_dataout = 32'h55;
        sb.push_back('{5'd7, 32'h55});
        tick();
        rfwb_op = 3'b000; wb_freeze = 1'b1;
        n_we = 0;
        for (int i = 0; i < 4; i++) begin
            check("frz_valid", 32'(wb_fwd_valid), 1);
            check("frz_forw",  wb_forw, 32'h55);
            if (rf_we === 1'b1) n_we++;
            if (i == 3) wb_freeze = 1'b0;
            tick();
        end
        check("frz_we_count", 32'(n_we), 1);

        // r0 destination and write-disabled op never produce a write.
        rfwb_op = 3'b001; ex_rfaddrw = 5'd0; alu_dataout = 32'hAAAA;
        tick();
        check("r0_we",    32'(rf_we), 0);
        check("r0_valid", 32'(wb_fwd_valid), 0);
        rfwb_op = 3'b000; ex_rfaddrw = 5'd4;
        tick();
        check("nowr_we",    32'(rf_we), 0);
        check("nowr_valid", 32'(wb_fwd_valid), 0);
        check("nowr_forw",  wb_forw, 32'h55);

        // Spurious lsu_ack in IDLE is ignored.
        lsu_ack = 1'b1; lsu_dataout = 32'h1234_5678;
        tick();
        lsu_ack = 1'b0;
        check("spur_forw",  wb_forw, 32'h55);
        check("spur_valid", 32'(wb_fwd_valid), 0);
        check("spur_stall", 32'(wb_stall), 0);

        // Reset while a load is pending abandons it.
        rfwb_op = 3'b011; ex_rfaddrw = 5'd6;
        tick();
        rfwb_op = 3'b000;
        check("rstld_stall", 32'(wb_stall), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; lsu_ack = 1'b1; lsu_dataout = 32'hCAFE;
        check("rstld_stall_off", 32'(wb_stall), 0);
        check("rstld_we",        32'(rf_we), 0);
        check("rstld_forw",      wb_forw, 0);
        tick();
        lsu_ack = 1'b0;
        check("rstld_ack_we",    32'(rf_we), 0);
        check("rstld_ack_valid", 32'(wb_fwd_valid), 0);
        check("rstld_ack_forw",  wb_forw, 0);
        tick();

        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
